// File: rtl/fifo_frame_reader.sv
// Read-side sequencer for the sample FIFO: drains fixed-length frames through a
// 2-entry skid buffer onto a valid/ready stream with sof/eof markers.
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic                  cfg_continuous,
    input  logic                  start,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           stall_cnt
);
    localparam logic [LEN_WIDTH:0]   FRAME_LEN_C = (LEN_WIDTH+1)'(FRAME_LEN);
    localparam logic [LEN_WIDTH-1:0] LAST_IDX    = LEN_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [LEN_WIDTH:0]    issue_cnt;
    logic [LEN_WIDTH-1:0]  out_cnt;
    logic [DATA_WIDTH-1:0] skid_mem [2];
    logic                  wr_ptr, rd_ptr, rd_vld;
    logic [1:0]            skid_cnt, occ;
    logic                  run, pop, last_pop, can_issue, start_frame;

    assign run         = (state == RUN);
    assign pop         = m_valid & m_ready;
    assign last_pop    = pop & m_eof;
    // Occupancy counts the read in flight plus buffered entries, net of this cycle's pop.
    assign occ         = skid_cnt + {1'b0, rd_vld} - {1'b0, pop};
    assign can_issue   = run && (issue_cnt < FRAME_LEN_C) && (occ < 2'd2);
    assign fifo_rd_en  = can_issue & ~fifo_rd_empty;
    assign start_frame = (state == IDLE) && cfg_en && (start || cfg_continuous);

    assign m_valid    = (skid_cnt != 2'd0);
    assign m_data     = skid_mem[rd_ptr];
    assign m_sof      = m_valid && (out_cnt == '0);
    assign m_eof      = m_valid && (out_cnt == LAST_IDX);
    assign frame_done = last_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_frame) state_nxt = RUN;
            RUN:     if (last_pop && !(cfg_en && cfg_continuous)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Counters restart at frame entry and on every final accept, continuous or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else if (start_frame || last_pop) begin
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            if (fifo_rd_en) issue_cnt <= issue_cnt + (LEN_WIDTH+1)'(1);
            if (pop)        out_cnt   <= out_cnt + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld      <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            skid_cnt    <= 2'd0;
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
        end else begin
            rd_vld <= fifo_rd_en;
            if (rd_vld) begin
                skid_mem[wr_ptr] <= fifo_rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            skid_cnt <= skid_cnt + {1'b0, rd_vld} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (can_issue && fifo_rd_empty && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with FRAME_LEN=8 against a behavioural
// FIFO whose read data appears one cycle after an accepted read.
module tb_fifo_frame_reader;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_en = 1'b0, cfg_continuous = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic        fifo_rd_en, fifo_rd_empty;
    logic [15:0] fifo_rd_data = 16'h0;
    logic [15:0] m_data, stall_cnt;
    logic        m_valid, m_sof, m_eof, busy, frame_done;

    int total = 0, bad = 0;

    logic [15:0] fmem [0:127];
    int wp = 0, rp = 0;

    logic [15:0] bd [0:127];
    logic        bs [0:127];
    logic        be [0:127];
    int nb = 0, fd = 0, occ_m = 0, occ_err = 0, rd_err = 0, hold_err = 0;
    logic        prev_hold = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;
    logic [15:0] prev_data = 16'h0;

    fifo_frame_reader #(.DATA_WIDTH(16), .FRAME_LEN(8), .LEN_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_continuous(cfg_continuous),
        .start(start), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_sof(m_sof), .m_eof(m_eof), .busy(busy),
        .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_rd_empty = (rp == wp);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rp[6:0]];
            rp           <= rp + 1;
        end
    end

    // Scoreboard capture plus protocol watchers (empty reads, occupancy, hold stability).
    always @(posedge clk) begin
        if (!rst_n) begin
            occ_m     <= 0;
            prev_hold <= 1'b0;
        end else begin
            if (fifo_rd_en && fifo_rd_empty) rd_err <= rd_err + 1;
            if (prev_hold && !(m_valid && m_data === prev_data && m_sof === prev_sof && m_eof === prev_eof))
                hold_err <= hold_err + 1;
            prev_hold <= m_valid && !m_ready;
            prev_data <= m_data;
            prev_sof  <= m_sof;
            prev_eof  <= m_eof;
            if (m_valid && m_ready && nb < 128) begin
                bd[nb] <= m_data;
                bs[nb] <= m_sof;
                be[nb] <= m_eof;
                nb     <= nb + 1;
            end
            if (frame_done) fd <= fd + 1;
            if (occ_m + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0) > 2) occ_err <= occ_err + 1;
            occ_m <= occ_m + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            fmem[wp[6:0]] = 16'(first + k);
            wp = wp + 1;
        end
    endtask

    task automatic wait_beats(input string tag, input int n, input int lim);
        int k = 0;
        while (nb < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(nb >= n), 32'd1);
    endtask

    function automatic int data_err(input int b, input int n, input int v0);
        int e = 0;
        for (int k = 0; k < n; k++) if (bd[b+k] !== 16'(v0 + k)) e++;
        return e;
    endfunction

    function automatic int cnt_sof(input int b, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (bs[b+k]) c++;
        return c;
    endfunction

    function automatic int cnt_eof(input int b, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (be[b+k]) c++;
        return c;
    endfunction

    initial begin
        int base, fd0, gap, r0;
        logic [3:0] rpat;

        // Reset state
        tick(3);
        chk("rst m_valid", 32'(m_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst m_data", 32'(m_data), 0);
        chk("rst stall_cnt", 32'(stall_cnt), 0);
        chk("rst frame_done", 32'(frame_done), 0);
        push(1, 16);
        rst_n = 1'b1;
        cfg_en = 1'b1;
        m_ready = 1'b1;
        tick(2);

        // Single-shot frame, cycle by cycle
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t1 busy after start", 32'(busy), 1);
        chk("t1 valid lat1", 32'(m_valid), 0);
        tick(1);
        chk("t1 valid lat2", 32'(m_valid), 0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk($sformatf("t1 valid b%0d", k), 32'(m_valid), 1);
            chk($sformatf("t1 data b%0d", k), 32'(m_data), 32'(k));
            chk($sformatf("t1 sof b%0d", k), 32'(m_sof), 32'(k == 1));
            chk($sformatf("t1 eof b%0d", k), 32'(m_eof), 32'(k == 8));
            chk($sformatf("t1 done b%0d", k), 32'(frame_done), 32'(k == 8));
        end
        tick(1);
        chk("t1 idle", 32'(busy), 0);
        chk("t1 valid off", 32'(m_valid), 0);
        chk("t1 fifo head", 32'(fmem[rp[6:0]]), 32'h9);
        chk("t1 fifo level", 32'(wp - rp), 8);
        chk("t1 frame_done cnt", 32'(fd), 1);

        // Continuous: 24 samples -> 3 frames
        push(17, 16);
        base = nb; fd0 = fd; gap = 0;
        cfg_continuous = 1'b1;
        for (int k = 0; k < 200 && nb < base + 17; k++) begin
            @(negedge clk);
            if (!busy) gap++;
        end
        chk("t2 reach frame3", 32'(nb >= base + 17), 1);
        cfg_continuous = 1'b0;
        wait_beats("t2 wait end", base + 24, 100);
        tick(3);
        chk("t2 busy gap", 32'(gap), 0);
        chk("t2 beats", 32'(nb - base), 24);
        chk("t2 data", 32'(data_err(base, 24, 9)), 0);
        chk("t2 sof cnt", 32'(cnt_sof(base, 24)), 3);
        chk("t2 sof pos", 32'({bs[base], bs[base+8], bs[base+16]}), 32'h7);
        chk("t2 eof pos", 32'({be[base+7], be[base+15], be[base+23]}), 32'h7);
        chk("t2 done pulses", 32'(fd - fd0), 3);
        chk("t2 idle", 32'(busy), 0);

        // Backpressure 1,0,0,1 with a start pulse mid-frame
        push(33, 8);
        base = nb; fd0 = fd;
        rpat = 4'b1001;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i > 2 && !busy) break;
            start   = (i == 0) || (i == 6);
            m_ready = rpat[i % 4];
        end
        start = 1'b0;
        m_ready = 1'b1;
        chk("t3 finished", 32'(busy), 0);
        tick(5);
        chk("t3 start ignored", 32'(busy), 0);
        chk("t3 beats", 32'(nb - base), 8);
        chk("t3 data", 32'(data_err(base, 8, 33)), 0);
        chk("t3 hold stable", 32'(hold_err), 0);
        chk("t3 sof/eof", 32'({bs[base], be[base+7], 8'(cnt_sof(base, 8)), 8'(cnt_eof(base, 8))}), 32'h30101);
        chk("t3 done", 32'(fd - fd0), 1);

        // Underrun after 3 samples, FIFO empty for 5 cycles
        chk("t4 stall before", 32'(stall_cnt), 0);
        push(41, 3);
        base = nb; fd0 = fd;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        chk("t4 valid gap", 32'(m_valid), 0);
        tick(2);
        push(44, 5);
        wait_beats("t4 wait end", base + 8, 60);
        tick(2);
        chk("t4 stall_cnt", 32'(stall_cnt), 5);
        chk("t4 data", 32'(data_err(base, 8, 41)), 0);
        chk("t4 sof once", 32'(cnt_sof(base, 8)), 1);
        chk("t4 sof first", 32'(bs[base]), 1);
        chk("t4 eof last", 32'({be[base+7], 8'(cnt_eof(base, 8))}), 32'h101);
        chk("t4 done", 32'(fd - fd0), 1);
        chk("t4 idle", 32'(busy), 0);

        // cfg_en dropped at sample 4 in continuous mode
        push(49, 16);
        base = nb; fd0 = fd;
        cfg_continuous = 1'b1;
        wait_beats("t5 reach b4", base + 4, 40);
        cfg_en = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_beats("t5 wait end", base + 8, 40);
        tick(10);
        chk("t5 beats", 32'(nb - base), 8);
        chk("t5 data", 32'(data_err(base, 8, 49)), 0);
        chk("t5 eof last", 32'(be[base+7]), 1);
        chk("t5 done", 32'(fd - fd0), 1);
        chk("t5 idle", 32'(busy), 0);
        chk("t5 fifo level", 32'(wp - rp), 8);

        // Reset at sample 5, then a fresh frame
        cfg_continuous = 1'b0;
        cfg_en = 1'b1;
        base = nb;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_beats("t6 reach b5", base + 5, 40);
        rst_n = 1'b0;
        #1;
        chk("t6 rst valid", 32'(m_valid), 0);
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst rd_en", 32'(fifo_rd_en), 0);
        chk("t6 rst stall", 32'(stall_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        push(65, 8);
        r0 = rp;
        base = nb; fd0 = fd;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_beats("t6 wait end", base + 8, 40);
        tick(2);
        chk("t6 first word", 32'(bd[base]), 32'(fmem[r0[6:0]]));
        chk("t6 data", 32'(data_err(base, 8, 32'(fmem[r0[6:0]]))), 0);
        chk("t6 sof/eof", 32'({bs[base], be[base+7], 8'(cnt_sof(base, 8))}), 32'h301);
        chk("t6 done", 32'(fd - fd0), 1);

        chk("no read while empty", 32'(rd_err), 0);
        chk("occupancy <= 2", 32'(occ_err), 0);
        chk("hold stable overall", 32'(hold_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
